// File: rtl/mem_data_arbiter.sv
// rtl/mem_data_arbiter.sv - two-requester round-robin arbiter for the Memory data port
module mem_data_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    input  logic        write0,
    input  logic        write1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  rdata0,
    output logic [7:0]  rdata1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_write,
    output logic        mem_req,
    input  logic        mem_done,
    input  logic [7:0]  mem_dout,
    output logic [1:0]  grant,
    output logic        busy
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic          last, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          done0_n, done1_n, err0_n, err1_n;
    logic [7:0]    rdata0_n, rdata1_n;
    logic [15:0]   mem_addr_n;
    logic [7:0]    mem_din_n;
    logic          mem_write_n, mem_req_n, busy_n;
    logic [1:0]    grant_n;
    logic          win0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            last      <= 1'b1;
            cnt       <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= 8'h00;
            rdata1    <= 8'h00;
            mem_addr  <= 16'h0000;
            mem_din   <= 8'h00;
            mem_write <= 1'b0;
            mem_req   <= 1'b0;
            grant     <= 2'b00;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            cnt       <= cnt_n;
            done0     <= done0_n;
            done1     <= done1_n;
            err0      <= err0_n;
            err1      <= err1_n;
            rdata0    <= rdata0_n;
            rdata1    <= rdata1_n;
            mem_addr  <= mem_addr_n;
            mem_din   <= mem_din_n;
            mem_write <= mem_write_n;
            mem_req   <= mem_req_n;
            grant     <= grant_n;
            busy      <= busy_n;
        end
    end

    // On a tie the requester that did not win last time is chosen.
    assign win0 = req0 && (!req1 || last);

    always_comb begin
        state_n     = state;
        last_n      = last;
        cnt_n       = cnt;
        done0_n     = 1'b0;
        done1_n     = 1'b0;
        err0_n      = 1'b0;
        err1_n      = 1'b0;
        rdata0_n    = rdata0;
        rdata1_n    = rdata1;
        mem_addr_n  = mem_addr;
        mem_din_n   = mem_din;
        mem_write_n = mem_write;
        mem_req_n   = mem_req;
        grant_n     = grant;
        busy_n      = busy;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    mem_addr_n  = win0 ? addr0  : addr1;
                    mem_din_n   = win0 ? wdata0 : wdata1;
                    mem_write_n = win0 ? write0 : write1;
                    mem_req_n   = 1'b1;
                    grant_n     = win0 ? 2'b01 : 2'b10;
                    last_n      = !win0;
                    cnt_n       = '0;
                    busy_n      = 1'b1;
                    state_n     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_done) begin
                    mem_req_n = 1'b0;
                    if (!mem_write) begin
                        if (grant[0]) rdata0_n = mem_dout;
                        else          rdata1_n = mem_dout;
                    end
                    done0_n = grant[0];
                    done1_n = grant[1];
                    state_n = S_RELEASE;
                end else if (WD_EN && (cnt == CNT_LAST)) begin
                    mem_req_n = 1'b0;
                    if (grant[0]) rdata0_n = 8'hFF;
                    else          rdata1_n = 8'hFF;
                    done0_n = grant[0];
                    done1_n = grant[1];
                    err0_n  = grant[0];
                    err1_n  = grant[1];
                    state_n = S_RELEASE;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                grant_n = 2'b00;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                mem_req_n = 1'b0;
                grant_n   = 2'b00;
                busy_n    = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// tb/tb_mem_data_arbiter.sv - self-checking bench for mem_data_arbiter
module tb_mem_data_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        req0, req1, write0, write1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        done0, done1, err0, err1;
    logic [7:0]  rdata0, rdata1;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_write, mem_req, mem_done, busy;
    logic [1:0]  grant;

    logic        b_req0;
    logic        b_done0, b_done1, b_err0, b_err1, b_mem_write, b_mem_req, b_busy;
    logic [7:0]  b_rdata0, b_rdata1, b_mem_din;
    logic [15:0] b_mem_addr;
    logic [1:0]  b_grant;

    mem_data_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .write0(write0), .write1(write1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_write(mem_write), .mem_req(mem_req),
        .mem_done(mem_done), .mem_dout(mem_dout), .grant(grant), .busy(busy)
    );

    mem_data_arbiter #(.TIMEOUT_CYCLES(0)) dut_nowd (
        .clock(clock), .reset(reset),
        .req0(b_req0), .req1(1'b0), .addr0(16'h1234), .addr1(16'h0000),
        .wdata0(8'h00), .wdata1(8'h00), .write0(1'b0), .write1(1'b0),
        .done0(b_done0), .done1(b_done1), .rdata0(b_rdata0), .rdata1(b_rdata1),
        .err0(b_err0), .err1(b_err1),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_write(b_mem_write), .mem_req(b_mem_req),
        .mem_done(1'b0), .mem_dout(8'h00), .grant(b_grant), .busy(b_busy)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_arr [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] ref_rdata [2];
    bit         ref_last;

    bit mem_mute, spur_pending, responded;
    int lat_min, lat_max, lat_cnt;

    int cyc = 0;
    initial forever @(posedge clock) cyc++;

    // Memory responder: one-cycle mem_done after a random latency.
    initial begin
        mem_done = 1'b0; mem_dout = 8'h00; responded = 0; lat_cnt = 0;
        forever begin
            @(negedge clock);
            mem_done = 1'b0;
            if (spur_pending) begin
                mem_done = 1'b1; mem_dout = 8'h5A; spur_pending = 0;
            end else if (!mem_req) begin
                responded = 0;
                lat_cnt = $urandom_range(lat_max, lat_min);
            end else if (!responded && !mem_mute) begin
                if (lat_cnt == 0) begin
                    mem_done = 1'b1; responded = 1;
                    if (mem_write) begin
                        mem_arr[mem_addr[7:0]] = mem_din;
                        mem_dout = 8'($urandom);
                    end else begin
                        mem_dout = mem_arr[mem_addr[7:0]];
                    end
                end else begin
                    lat_cnt--;
                end
            end
        end
    end

    // Captures the command presented to memory on each rising mem_req.
    int          g_count = 0, g_edge = 0;
    logic [1:0]  g_grant;
    logic [15:0] g_addr;
    logic [7:0]  g_din;
    logic        g_write;
    bit          prev_req = 0;
    initial forever begin
        @(negedge clock);
        if (mem_req && !prev_req) begin
            g_count++; g_grant = grant; g_addr = mem_addr;
            g_din = mem_din; g_write = mem_write; g_edge = cyc;
        end
        prev_req = mem_req;
    end

    task automatic tick();
        @(negedge clock); #1;
    endtask

    task automatic wait_done(output int who, output int edge_no, output bit tmo);
        who = -1; edge_no = 0; tmo = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done0 || done1) begin
                who = (done0 && done1) ? 2 : (done0 ? 0 : 1);
                edge_no = cyc; tmo = 0;
                return;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        ref_last = 1; ref_rdata[0] = 8'h00; ref_rdata[1] = 8'h00;
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({done0, done1, err0, err1, mem_req, mem_write, busy, grant} !== 9'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=0", {done0, done1, err0, err1, mem_req, mem_write, busy, grant}); end
        checks++; if ({rdata0, rdata1} !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata got=%h exp=0000", {rdata0, rdata1}); end
        checks++; if ({mem_addr, mem_din} !== 24'h0) begin
            errors++; $display("FAIL reset_mem got=%h exp=0", {mem_addr, mem_din}); end
        tick(); tick(); reset = 1'b0; tick(); tick();
        checks++; if ({grant, busy, mem_req} !== 4'b0) begin
            errors++; $display("FAIL reset_idle got=%b exp=0", {grant, busy, mem_req}); end
    endtask

    task automatic test_single_read();
        int who, e, gc; bit tmo;
        mem_arr[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
        lat_min = 1; lat_max = 1; tick();
        addr0 = 16'h0010; write0 = 1'b0; req0 = 1'b1; gc = g_count;
        wait_done(who, e, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL single_timeout got=none exp=done0"); end
        checks++; if (who !== 0) begin errors++; $display("FAIL single_who got=%0d exp=0", who); end
        checks++; if (g_count !== gc + 1 || g_grant !== 2'b01) begin
            errors++; $display("FAIL single_grant got=%0d/%b exp=%0d/01", g_count, g_grant, gc + 1); end
        checks++; if (g_addr !== 16'h0010 || g_write !== 1'b0) begin
            errors++; $display("FAIL single_cmd got=%h/%b exp=0010/0", g_addr, g_write); end
        checks++; if (rdata0 !== 8'hA5 || err0 !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL single_result got=%h/%b/%b exp=a5/0/0", rdata0, err0, mem_req); end
        checks++; if (e - g_edge !== 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", e - g_edge); end
        req0 = 1'b0; tick();
        checks++; if (done0 !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL single_release got=%b/%b/%b exp=0/00/0", done0, grant, busy); end
        ref_rdata[0] = 8'hA5; ref_last = 0;
    endtask

    task automatic test_spurious();
        int pulses = 0;
        spur_pending = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(done0 | done1 | err0 | err1 | mem_req | busy | (grant != 2'b00));
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL spurious_activity got=%0d exp=0", pulses); end
        checks++; if (rdata0 !== ref_rdata[0] || rdata1 !== ref_rdata[1]) begin
            errors++; $display("FAIL spurious_rdata got=%h/%h exp=%h/%h", rdata0, rdata1, ref_rdata[0], ref_rdata[1]); end
    endtask

    task automatic test_loader_burst();
        int who, e, gc; bit tmo;
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 4; i++) begin
            addr1 = 16'(i); wdata1 = 8'(8'h11 + i); write1 = 1'b1; req1 = 1'b1; gc = g_count;
            wait_done(who, e, tmo);
            checks++; if (tmo || who !== 1) begin errors++; $display("FAIL burst_who[%0d] got=%0d exp=1", i, who); end
            checks++; if (g_count !== gc + 1 || g_grant !== 2'b10 || g_write !== 1'b1) begin
                errors++; $display("FAIL burst_grant[%0d] got=%b/%b exp=10/1", i, g_grant, g_write); end
            checks++; if (g_addr !== 16'(i) || g_din !== 8'(8'h11 + i)) begin
                errors++; $display("FAIL burst_cmd[%0d] got=%h/%h exp=%h/%h", i, g_addr, g_din, 16'(i), 8'(8'h11 + i)); end
            checks++; if (rdata1 !== ref_rdata[1] || err1 !== 1'b0) begin
                errors++; $display("FAIL burst_rdata[%0d] got=%h/%b exp=%h/0", i, rdata1, err1, ref_rdata[1]); end
            ref_mem[i] = 8'(8'h11 + i); ref_last = 1;
            req1 = 1'b0; tick();
        end
        write1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int who, e, gc, exp_r; bit tmo;
        do_reset();
        lat_min = 0; lat_max = 2;
        addr0 = 16'h0003; addr1 = 16'h0040; write0 = 1'b0; write1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_r = ref_last ? 0 : 1;
            gc = g_count;
            wait_done(who, e, tmo);
            checks++; if (tmo || who !== exp_r) begin errors++; $display("FAIL b2b_who[%0d] got=%0d exp=%0d", n, who, exp_r); end
            checks++; if (g_count !== gc + 1 || g_grant !== (exp_r ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL b2b_grant[%0d] got=%0d/%b exp=%0d/%b", n, g_count, g_grant, gc + 1, exp_r ? 2'b10 : 2'b01); end
            ref_rdata[exp_r] = ref_mem[exp_r ? 8'h40 : 8'h03]; ref_last = exp_r[0];
            checks++; if ((exp_r ? rdata1 : rdata0) !== ref_rdata[exp_r]) begin
                errors++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", n, exp_r ? rdata1 : rdata0, ref_rdata[exp_r]); end
            if (n == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (exp_r == 0) req0 = 1'b0; else req1 = 1'b0;
                tick();
                req0 = 1'b1; req1 = 1'b1;
            end
        end
        tick(); tick();
    endtask

    task automatic test_random();
        int who, e, gc, exp_r, first, nacc, pat;
        bit tmo;
        bit act [2];
        logic [15:0] a [2];
        logic [7:0]  d [2];
        logic        w [2];
        lat_min = 0; lat_max = 4;
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < 20 && busy; k++) tick();
            pat = $urandom_range(2, 0);
            act[0] = (pat != 1); act[1] = (pat != 0);
            for (int r = 0; r < 2; r++) begin
                a[r] = 16'($urandom); d[r] = 8'($urandom); w[r] = 1'($urandom_range(1, 0));
            end
            addr0 = a[0]; wdata0 = d[0]; write0 = w[0]; req0 = act[0];
            addr1 = a[1]; wdata1 = d[1]; write1 = w[1]; req1 = act[1];
            first = (act[0] && act[1]) ? (ref_last ? 0 : 1) : (act[0] ? 0 : 1);
            nacc = int'(act[0]) + int'(act[1]);
            for (int n = 0; n < nacc; n++) begin
                exp_r = (n == 0) ? first : 1 - first;
                gc = g_count;
                wait_done(who, e, tmo);
                checks++; if (tmo || who !== exp_r) begin errors++; $display("FAIL rnd_who[%0d] got=%0d exp=%0d", it, who, exp_r); end
                checks++; if (g_count !== gc + 1 || g_grant !== (exp_r ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rnd_grant[%0d] got=%b exp=%b", it, g_grant, exp_r ? 2'b10 : 2'b01); end
                checks++; if (g_addr !== a[exp_r] || g_write !== w[exp_r] || (w[exp_r] && g_din !== d[exp_r])) begin
                    errors++; $display("FAIL rnd_cmd[%0d] got=%h/%b/%h exp=%h/%b/%h", it, g_addr, g_write, g_din, a[exp_r], w[exp_r], d[exp_r]); end
                if (w[exp_r]) ref_mem[a[exp_r][7:0]] = d[exp_r];
                else          ref_rdata[exp_r] = ref_mem[a[exp_r][7:0]];
                ref_last = exp_r[0];
                checks++; if ((exp_r ? rdata1 : rdata0) !== ref_rdata[exp_r] || (err0 | err1) !== 1'b0) begin
                    errors++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", it, exp_r ? rdata1 : rdata0, ref_rdata[exp_r]); end
                if (exp_r == 0) req0 = 1'b0; else req1 = 1'b0;
            end
            tick();
        end
        write0 = 1'b0; write1 = 1'b0;
    endtask

    task automatic test_watchdog();
        int who, e; bit tmo;
        mem_mute = 1; tick();
        addr0 = 16'h0077; write0 = 1'b0; req0 = 1'b1;
        wait_done(who, e, tmo);
        checks++; if (tmo || who !== 0) begin errors++; $display("FAIL wd_who got=%0d exp=0", who); end
        checks++; if (err0 !== 1'b1 || err1 !== 1'b0) begin errors++; $display("FAIL wd_err got=%b/%b exp=1/0", err0, err1); end
        checks++; if (rdata0 !== 8'hFF || mem_req !== 1'b0) begin
            errors++; $display("FAIL wd_result got=%h/%b exp=ff/0", rdata0, mem_req); end
        checks++; if (e - g_edge !== 8) begin errors++; $display("FAIL wd_latency got=%0d exp=8", e - g_edge); end
        req0 = 1'b0; tick();
        checks++; if (err0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL wd_pulse got=%b/%b exp=0/0", err0, done0); end
        ref_rdata[0] = 8'hFF; ref_last = 0;
        mem_mute = 0; tick();
    endtask

    task automatic test_no_watchdog();
        int pulses = 0;
        b_req0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            pulses += int'(b_done0 | b_err0);
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL nowd_pulses got=%0d exp=0", pulses); end
        checks++; if ({b_mem_req, b_busy, b_grant} !== 4'b1101) begin
            errors++; $display("FAIL nowd_state got=%b exp=1101", {b_mem_req, b_busy, b_grant}); end
        b_req0 = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int who, e, pulses; bit tmo;
        mem_mute = 1;
        addr0 = 16'h0020; write0 = 1'b0; req0 = 1'b1;
        tick(); tick();
        checks++; if (mem_req !== 1'b1 || grant !== 2'b01) begin
            errors++; $display("FAIL rstmid_busy got=%b/%b exp=1/01", mem_req, grant); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({mem_req, grant, busy, done0} !== 5'b0) begin
            errors++; $display("FAIL rstmid_async got=%b exp=0", {mem_req, grant, busy, done0}); end
        req0 = 1'b0; pulses = 0;
        for (int i = 0; i < 3; i++) begin tick(); pulses += int'(done0 | err0); end
        reset = 1'b0; tick();
        pulses += int'(done0 | err0);
        checks++; if (pulses !== 0 || rdata0 !== 8'h00) begin
            errors++; $display("FAIL rstmid_nodone got=%0d/%h exp=0/00", pulses, rdata0); end
        ref_last = 1; ref_rdata[0] = 8'h00; ref_rdata[1] = 8'h00; mem_mute = 0;
        addr1 = 16'h0021; write1 = 1'b0;
        req1 = 1'b1; req0 = 1'b1;
        wait_done(who, e, tmo);
        checks++; if (tmo || who !== 0 || g_grant !== 2'b01) begin
            errors++; $display("FAIL rstmid_first got=%0d/%b exp=0/01", who, g_grant); end
        req0 = 1'b0;
        wait_done(who, e, tmo);
        checks++; if (tmo || who !== 1 || g_grant !== 2'b10) begin
            errors++; $display("FAIL rstmid_second got=%0d/%b exp=1/10", who, g_grant); end
        checks++; if (rdata1 !== ref_mem[8'h21]) begin
            errors++; $display("FAIL rstmid_rdata got=%h exp=%h", rdata1, ref_mem[8'h21]); end
        req1 = 1'b0; tick(); tick();
    endtask

    initial begin
        logic [7:0] v;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
        addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 8'h00; wdata1 = 8'h00;
        b_req0 = 1'b0;
        mem_mute = 0; spur_pending = 0; lat_min = 0; lat_max = 0;
        ref_last = 1; ref_rdata[0] = 8'h00; ref_rdata[1] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom); mem_arr[i] = v; ref_mem[i] = v;
        end
        test_reset();
        test_single_read();
        test_spurious();
        test_loader_burst();
        test_back_to_back();
        test_random();
        test_watchdog();
        test_no_watchdog();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
